// File: rtl/uart_tx_serializer_if.sv
// Handshake bundle between the TX FIFO read side and the UART serializer.
// master: the side that feeds bytes in (FIFO / controller / testbench).
// slave:  the serializer itself, which pops bytes and drives the pad.
interface uart_tx_serializer_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  tx_en;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  fifo_pop;
  logic                  txd;
  logic                  busy;
  logic                  frame_done;

  modport master (
    output tx_en,
    output fifo_empty,
    output fifo_data,
    input  fifo_pop,
    input  txd,
    input  busy,
    input  frame_done
  );

  modport slave (
    input  tx_en,
    input  fifo_empty,
    input  fifo_data,
    output fifo_pop,
    output txd,
    output busy,
    output frame_done
  );
endinterface

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: read side of the UART TX FIFO. Pops one byte at a time
// from a show-ahead FIFO and sends it as an 8N1 frame (LSB first) on txd.
// Every bit (start, data, parity, stop) lasts exactly CLKS_PER_BIT clocks and
// the FSM always spends at least one clock in IDLE between frames, so the
// back-to-back frame period is (bits_per_frame * CLKS_PER_BIT) + 1 clocks.
//
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// between the last data bit and the stop bit (11-bit frame). Without the
// macro there is no parity state and no parity logic.
//
// Reset is asynchronous and active low; asserting it forces txd high at once
// and abandons any frame in flight.
module uart_tx_serializer #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_WIDTH   = 8
) (
  input logic                 clk,
  input logic                 rstn,
  uart_tx_serializer_if.slave bus
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  // One clock before the end of a bit; lets frame_done be a registered pulse
  // that still lines up with the final clock of the stop bit.
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [IDX_W-1:0]      r_idx;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_txd;
  logic                  r_busy;
  logic                  r_frame_done;
`ifdef UART_TX_PARITY_EN
  logic                  r_parity;
`endif

  logic                  w_pop;
  logic                  w_cnt_term;
  logic                  w_last_bit;
  logic [DATA_WIDTH-1:0] w_shift_next;

  // The pop strobe is the only combinational output: it must be in the same
  // cycle as the show-ahead word it consumes. Gated by rstn so the FIFO is
  // never touched while the block is held in reset.
  assign w_pop        = rstn && (r_state == S_IDLE) && bus.tx_en && !bus.fifo_empty;
  assign w_cnt_term   = (r_cnt == CNT_LAST);
  assign w_last_bit   = (r_idx == IDX_LAST);
  assign w_shift_next = r_shift >> 1;

  assign bus.fifo_pop   = w_pop;
  assign bus.txd        = r_txd;
  assign bus.busy       = r_busy;
  assign bus.frame_done = r_frame_done;

  // Frame sequencer: bit timing, shift register and all registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_shift      <= '0;
      r_txd        <= 1'b1;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity     <= 1'b0;
`endif
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // The head word is captured only here; later changes on fifo_data
          // cannot disturb the frame.
          if (w_pop) begin
            r_shift <= bus.fifo_data;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_txd   <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_START;
`ifdef UART_TX_PARITY_EN
            r_parity <= ^bus.fifo_data;
`endif
          end
        end

        S_START: begin
          if (w_cnt_term) begin
            r_cnt   <= '0;
            r_txd   <= r_shift[0];
            r_state <= S_DATA;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        S_DATA: begin
          if (w_cnt_term) begin
            r_cnt <= '0;
            if (w_last_bit) begin
`ifdef UART_TX_PARITY_EN
              r_txd   <= r_parity;
              r_state <= S_PARITY;
`else
              r_txd   <= 1'b1;
              r_state <= S_STOP;
`endif
            end else begin
              r_idx   <= r_idx + IDX_W'(1);
              r_shift <= w_shift_next;
              r_txd   <= w_shift_next[0];
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (w_cnt_term) begin
            r_cnt   <= '0;
            r_txd   <= 1'b1;
            r_state <= S_STOP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
`endif

        S_STOP: begin
          if (r_cnt == CNT_PRE) begin
            r_frame_done <= 1'b1;
          end
          if (w_cnt_term) begin
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        default: begin
          r_cnt   <= '0;
          r_idx   <= '0;
          r_txd   <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // A pop is only legal when the FIFO has data and no frame is in flight.
  pop_legal_a: assert property (@(posedge clk) disable iff (!rstn)
    bus.fifo_pop |-> (!bus.fifo_empty && !bus.busy));

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer (CLKS_PER_BIT=4). A queue-based FIFO model feeds
// the DUT; every pop pushes the expected frame onto a scoreboard. An
// independent line monitor captures each frame clock by clock and compares it
// with the waveform rebuilt from the popped byte. Honours UART_TX_PARITY_EN.
module tb_uart_tx_serializer;

  localparam int N  = 4;
  localparam int DW = 8;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = DW + 3;
`else
  localparam int NBITS = DW + 2;
`endif
  localparam int FRAME_CLKS = NBITS * N;

  typedef struct {
    logic [7:0] data;
    int         pop_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rstn;

  uart_tx_serializer_if #(.DATA_WIDTH(DW)) bus ();

  uart_tx_serializer #(
    .CLKS_PER_BIT(N),
    .DATA_WIDTH  (DW)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  function automatic void check(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endfunction

  // Reference: value of frame bit b (0 = start) for byte d.
  function automatic logic frame_bit(logic [7:0] d, int b);
    if (b == 0) return 1'b0;
    if (b <= DW) return d[b-1];
`ifdef UART_TX_PARITY_EN
    if (b == DW + 1) return ^d;
`endif
    return 1'b1;
  endfunction

  // ---------------- FIFO model + scoreboard producer ----------------
  logic [7:0] fifo_q[$];
  exp_t       exp_q[$];
  int         pops = 0;
  logic       pend;
  int         pend_cyc;

  initial begin : fifo_model
    bus.fifo_empty = 1'b1;
    bus.fifo_data  = '0;
    forever begin
      @(negedge clk);
      #3;
      pend     = rstn && (bus.fifo_pop === 1'b1);
      pend_cyc = cyc;
      if (bus.fifo_pop !== 1'b0)
        check("pop_legal", {bus.fifo_pop, bus.fifo_empty, bus.busy, !rstn}, 4'b1000);
      @(posedge clk);
      #1;
      if (pend) begin
        if (fifo_q.size() > 0) begin
          exp_q.push_back('{data: fifo_q[0], pop_cyc: pend_cyc});
          void'(fifo_q.pop_front());
        end
        pops++;
      end
      bus.fifo_empty = (fifo_q.size() == 0);
      bus.fifo_data  = (fifo_q.size() == 0) ? 8'($urandom) : fifo_q[0];
    end
  end

  // ---------------- line monitor + scoreboard consumer ----------------
  int                    mon_start;
  int                    mon_starts   = 0;
  int                    frames_seen  = 0;
  int                    starts_q[$];
  logic [FRAME_CLKS-1:0] s_txd, s_fd, s_busy, exp_wave, exp_fd;
  logic [7:0]            dec;
  bit                    aborted;
  bit                    after_frame;
  exp_t                  e;

  initial begin : monitor
    after_frame = 1'b0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        after_frame = 1'b0;
      end else if (after_frame) begin
        after_frame = 1'b0;
        check("post_frame_idle", {bus.busy, bus.txd, bus.frame_done}, 3'b010);
      end else if (bus.txd === 1'b0) begin
        mon_start = cyc;
        mon_starts++;
        aborted = 1'b0;
        for (int k = 0; k < FRAME_CLKS; k++) begin
          if (k > 0) @(negedge clk);
          if (!rstn) begin
            aborted = 1'b1;
            break;
          end
          s_txd[k]  = bus.txd;
          s_fd[k]   = bus.frame_done;
          s_busy[k] = bus.busy;
        end
        if (!aborted) begin
          starts_q.push_back(mon_start);
          frames_seen++;
          after_frame = 1'b1;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL frame_unexpected: got frame at cycle %0d, expected none", mon_start);
          end else begin
            e = exp_q.pop_front();
            exp_fd = '0;
            exp_fd[FRAME_CLKS-1] = 1'b1;
            for (int k = 0; k < FRAME_CLKS; k++) exp_wave[k] = frame_bit(e.data, k / N);
            for (int i = 0; i < DW; i++) dec[i] = s_txd[(1 + i) * N + N / 2];
            check("frame_txd", s_txd, exp_wave);
            check("frame_data", dec, e.data);
            check("frame_done_pulse", s_fd, exp_fd);
            check("frame_busy", s_busy, {FRAME_CLKS{1'b1}});
            check("start_after_pop", mon_start, e.pop_cyc + 1);
          end
        end
      end else begin
        check("idle_no_frame_done", bus.frame_done, 1'b0);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic wait_drain(string name, int budget);
    int n = 0;
    while (!(fifo_q.size() == 0 && exp_q.size() == 0 && bus.busy === 1'b0) && n < budget) begin
      tick();
      n++;
    end
    check({"drain_", name}, (n >= budget), 1'b0);
  endtask

  task automatic wait_idle(string name, int budget);
    int n = 0;
    while (!(exp_q.size() == 0 && bus.busy === 1'b0) && n < budget) begin
      tick();
      n++;
    end
    check({"idle_", name}, (n >= budget), 1'b0);
  endtask

  task automatic wait_starts(string name, int target, int budget);
    int n = 0;
    while (mon_starts < target && n < budget) begin
      tick();
      n++;
    end
    check({"start_", name}, (n >= budget), 1'b0);
  endtask

  initial begin : watchdog
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: simulation did not finish within 60000 cycles");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  int p0, f0, s0, ns0, bad;

  initial begin : stimulus
    rstn       = 1'b0;
    bus.tx_en  = 1'b0;
    repeat (3) tick();
    check("reset_outputs", {bus.txd, bus.busy, bus.frame_done, bus.fifo_pop}, 4'b1000);
    rstn = 1'b1;
    tick();

    // Empty FIFO with tx_en high: line stays idle, no pops.
    bus.tx_en = 1'b1;
    bad = 0;
    repeat (100) begin
      tick();
      if (bus.txd !== 1'b1 || bus.busy !== 1'b0 || bus.fifo_pop !== 1'b0 || bus.frame_done !== 1'b0)
        bad++;
    end
    check("idle_empty_violations", bad, 0);
    check("idle_empty_pops", pops, 0);

    // Single bytes, including parity corner values.
    p0 = pops; f0 = frames_seen;
    fifo_q.push_back(8'hA5);
    wait_drain("a5", 200);
    check("a5_pops", pops - p0, 1);
    check("a5_frames", frames_seen - f0, 1);
    fifo_q.push_back(8'h07);
    wait_drain("07", 200);
    fifo_q.push_back(8'h03);
    wait_drain("03", 200);

    // Back-to-back frames.
    p0 = pops; ns0 = starts_q.size();
    fifo_q.push_back(8'h00);
    fifo_q.push_back(8'hFF);
    wait_drain("b2b", 400);
    check("b2b_pops", pops - p0, 2);
    if (starts_q.size() >= ns0 + 2)
      check("b2b_period", starts_q[ns0+1] - starts_q[ns0], FRAME_CLKS + 1);
    else
      check("b2b_frame_count", starts_q.size() - ns0, 2);

    // tx_en dropped mid-frame: current frame finishes, nothing else popped.
    p0 = pops; s0 = mon_starts;
    fifo_q.push_back(8'h11);
    fifo_q.push_back(8'h22);
    fifo_q.push_back(8'h33);
    wait_starts("txen", s0 + 1, 100);
    repeat (2) tick();
    bus.tx_en = 1'b0;
    wait_idle("txen", 200);
    repeat (60) tick();
    check("txen_pops", pops - p0, 1);
    check("txen_fifo_left", fifo_q.size(), 2);
    check("txen_line_idle", {bus.txd, bus.busy}, 2'b10);
    bus.tx_en = 1'b1;
    wait_drain("txen_flush", 400);

    // Reset asserted during data bit 3 (0x37 has bit 3 low).
    p0 = pops; f0 = frames_seen; s0 = mon_starts;
    fifo_q.push_back(8'h37);
    fifo_q.push_back(8'h5A);
    wait_starts("rst", s0 + 1, 100);
    repeat (4 * N + 1) tick();
    check("pre_reset_txd", bus.txd, 1'b0);
    rstn = 1'b0;
    exp_q.delete();
    #1;
    check("reset_async_txd", {bus.txd, bus.busy}, 2'b10);
    repeat (3) tick();
    check("reset_hold_no_pop", {bus.fifo_pop, bus.txd}, 2'b01);
    rstn = 1'b1;
    wait_drain("rst", 300);
    check("rst_pops", pops - p0, 2);
    check("rst_frames", frames_seen - f0, 1);

    // Randomized traffic with tx_en toggling.
    p0 = pops; f0 = frames_seen;
    for (int i = 0; i < 16; i++) begin
      fifo_q.push_back(8'($urandom));
      if ($urandom_range(3) == 0) bus.tx_en = ~bus.tx_en;
      repeat ($urandom_range(60)) tick();
    end
    bus.tx_en = 1'b1;
    wait_drain("random", 16 * (FRAME_CLKS + 2) + 200);
    check("random_pops", pops - p0, 16);
    check("random_frames", frames_seen - f0, 16);

    repeat (5) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
